// File: rtl/smc_result_collector.sv
// Result collector: frames the SMC result stream into a FIFO drained through a valid/ready port.
// Optional running checksum output enabled by defining SMC_COLLECT_CHKSUM_EN.
module smc_result_collector #(
    parameter int unsigned DATA_W    = 10,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned FRAME_LEN = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [DATA_W-1:0]        out_n,
    input  logic                     Enable,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     overflow,
    output logic                     stray,
    output logic [$clog2(DEPTH):0]   level
`ifdef SMC_COLLECT_CHKSUM_EN
    ,
    output logic [15:0]              chksum
`endif
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              stray_q, stray_d;
    logic              busy_q;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]   level_q, level_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic full, empty, pop, collect_en, push, drop;

    assign full       = (level_q == LvlW'(DEPTH));
    assign empty      = (level_q == '0);
    assign pop        = !empty && rd_ready;
    assign collect_en = (state_q == StCollect) && Enable;
    // A pop frees the slot on the same edge, so a full FIFO still accepts the write.
    assign push       = collect_en && (!full || pop);
    assign drop       = collect_en && full && !pop;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        stray_d = stray_q | (Enable && (state_q != StCollect));
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StCollect;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            StCollect: begin
                if (Enable) begin
                    cnt_d = cnt_q + 8'd1;
                    if (drop) ovf_d = 1'b1;
                    if (cnt_d == 8'(FRAME_LEN)) state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) level_d = level_q + LvlW'(1);
        else if (pop && !push) level_d = level_q - LvlW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            stray_q  <= 1'b0;
            busy_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            stray_q  <= stray_d;
            busy_q   <= (state_d == StCollect);
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= out_n;
        end
    end

`ifdef SMC_COLLECT_CHKSUM_EN
    logic [15:0] chk_q, chk_d;

    always_comb begin
        chk_d = chk_q;
        if (state_q == StIdle && start) chk_d = '0;
        else if (push) chk_d = chk_q + 16'(out_n);
    end

    always_ff @(posedge clk) begin
        if (!reset) chk_q <= '0;
        else        chk_q <= chk_d;
    end

    assign chksum = chk_q;
`endif

    assign rd_valid   = !empty;
    assign rd_data    = mem_q[rd_ptr_q];
    assign busy       = busy_q;
    assign frame_done = (state_q == StDone);
    assign overflow   = ovf_q;
    assign stray      = stray_q;
    assign level      = level_q;
endmodule

// File: tb/tb_smc_result_collector.sv
// Randomized self-checking bench for smc_result_collector against a queue-based model.
module tb_smc_result_collector;
    localparam int DATA_W = 10;
    localparam int DEPTH = 8;
    localparam int FRAME_LEN = 6;

    logic clk = 1'b0;
    logic reset, start, Enable, rd_ready;
    logic [DATA_W-1:0] out_n;
    logic rd_valid, busy, frame_done, overflow, stray;
    logic [DATA_W-1:0] rd_data;
    logic [$clog2(DEPTH):0] level;
`ifdef SMC_COLLECT_CHKSUM_EN
    logic [15:0] chksum;
`endif

    smc_result_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)) dut (
        .clk(clk), .reset(reset), .start(start), .out_n(out_n), .Enable(Enable),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .busy(busy),
        .frame_done(frame_done), .overflow(overflow), .stray(stray), .level(level)
`ifdef SMC_COLLECT_CHKSUM_EN
        , .chksum(chksum)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int fd_count = 0;
    int rd_log[$];

    // Behavioural model: phase 0 idle, 1 collecting, 2 frame just completed.
    int m_phase = 0;
    int m_cnt = 0;
    int m_ovf = 0;
    int m_stray = 0;
    int m_chk = 0;
    int m_q[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit do_pop, do_push;
        do_pop = 0;
        do_push = 0;
        if (!reset) begin
            m_phase = 0; m_cnt = 0; m_ovf = 0; m_stray = 0; m_chk = 0;
            m_q.delete();
        end else begin
            do_pop = (m_q.size() > 0) && rd_ready;
            if (m_phase == 1) begin
                if (Enable) begin
                    m_cnt++;
                    if (m_q.size() < DEPTH || do_pop) do_push = 1;
                    else m_ovf = 1;
                    if (m_cnt == FRAME_LEN) m_phase = 2;
                end
            end else begin
                if (Enable) m_stray = 1;
                if (m_phase == 2) m_phase = 0;
                else if (start) begin
                    m_phase = 1; m_cnt = 0; m_ovf = 0; m_chk = 0;
                end
            end
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                m_q.push_back(int'(out_n));
                m_chk = (m_chk + int'(out_n)) % 65536;
            end
        end
    endtask

    always @(posedge clk) begin
        if (rd_valid && rd_ready) rd_log.push_back(int'(rd_data));
        model_step();
        #1;
        check("level", int'(level), m_q.size());
        check("rd_valid", int'(rd_valid), int'(m_q.size() > 0));
        if (m_q.size() > 0) check("rd_data", int'(rd_data), m_q[0]);
        check("busy", int'(busy), int'(m_phase == 1));
        check("frame_done", int'(frame_done), int'(m_phase == 2));
        check("overflow", int'(overflow), m_ovf);
        check("stray", int'(stray), m_stray);
`ifdef SMC_COLLECT_CHKSUM_EN
        check("chksum", int'(chksum), m_chk);
`endif
        if (frame_done) fd_count++;
    end

    task automatic cyc(input bit st, input bit en, input int d, input bit rr);
        start = st;
        Enable = en;
        out_n = DATA_W'(d);
        rd_ready = rr;
        @(negedge clk);
    endtask

    int sent[$];
    int exp9[9] = '{10, 20, 30, 40, 50, 60, 70, 80, 99};

    initial begin
        reset = 1'b0; start = 1'b0; Enable = 1'b0; rd_ready = 1'b0; out_n = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) cyc(0, 0, 0, 0);
        check("rst_level", int'(level), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_flags", int'({frame_done, overflow, stray}), 0);

        // Reset part-way through a frame.
        cyc(1, 0, 0, 0);
        for (int i = 1; i <= 3; i++) cyc(0, 1, i, 0);
        reset = 1'b0;
        cyc(0, 0, 0, 0);
        reset = 1'b1;
        check("midrst_level", int'(level), 0);
        check("midrst_busy", int'(busy), 0);

        // Frame of 10..60 held in the FIFO.
        rd_log.delete();
        fd_count = 0;
        cyc(1, 0, 0, 0);
        for (int i = 1; i <= 6; i++) cyc(0, 1, 10 * i, 0);
        repeat (2) cyc(0, 0, 0, 0);
        check("f1_done_pulses", fd_count, 1);
        check("f1_level", int'(level), 6);
        check("f1_overflow", int'(overflow), 0);
`ifdef SMC_COLLECT_CHKSUM_EN
        check("f1_chksum", int'(chksum), 210);
`endif

        // Fill to full, push with a simultaneous pop, then overflow.
        cyc(1, 0, 0, 0);
        cyc(0, 1, 70, 0);
        cyc(0, 1, 80, 0);
        check("full_level", int'(level), 8);
        cyc(0, 1, 99, 1);
        check("pushpop_level", int'(level), 8);
        check("pushpop_overflow", int'(overflow), 0);
        for (int i = 1; i <= 3; i++) cyc(0, 1, i, 0);
        repeat (2) cyc(0, 0, 0, 0);
        check("ovf_flag", int'(overflow), 1);
        check("ovf_level", int'(level), 8);
        check("f2_done_pulses", fd_count, 2);
        repeat (10) cyc(0, 0, 0, 1);
        check("drain_count", rd_log.size(), 9);
        for (int i = 0; i < 9; i++) begin
            if (i < rd_log.size()) check("drain_order", rd_log[i], exp9[i]);
        end

        // Stray result while idle.
        cyc(0, 1, 7, 0);
        check("stray_set", int'(stray), 1);
        check("stray_level", int'(level), 0);
        cyc(1, 0, 0, 0);
        check("stray_kept", int'(stray), 1);

        // Three frames with a continuously ready consumer (already collecting).
        rd_log.delete();
        sent.delete();
        for (int f = 0; f < 3; f++) begin
            if (f != 0) begin
                cyc(0, 0, 0, 1);
                cyc(1, 0, 0, 1);
            end
            for (int i = 0; i < 6; i++) begin
                int v;
                v = int'($urandom_range(0, 1023));
                sent.push_back(v);
                cyc(0, 1, v, 1);
                check("wrap_level", int'(level), 1);
            end
        end
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        check("wrap_count", rd_log.size(), 18);
        for (int i = 0; i < 18; i++) begin
            if (i < rd_log.size()) check("wrap_order", rd_log[i], sent[i]);
        end

        // Randomized traffic with varying consumer pressure and rare resets.
        for (int i = 0; i < 3000; i++) begin
            bit rr;
            rr = ((i / 300) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 299) != 0);
            cyc($urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0,
                int'($urandom_range(0, 1023)), rr);
        end
        reset = 1'b1;
        repeat (2) cyc(0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/smc_result_collector.md
# smc_result_collector

Captures the result stream produced by the SMC datapath (`out_n` qualified by `Enable`) and buffers it for a downstream reader. It sits on the output side of SMC, opposite the stimulus driver. It groups results into fixed-length frames and reports completion. It also reports overflow, and optionally a running checksum. A consumer drains results through a valid/ready read port.

## Interface

Parameters:
- `DATA_W`, 10, width of `out_n` and `rd_data`
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `FRAME_LEN`, 6, results per frame; 1..255

Ports:
- `clk` in 1 — single clock; all logic is rising-edge.
- `reset` in 1 — synchronous, active-low.
- `start` in 1 — one-cycle pulse; arms a new frame.
- `out_n` in DATA_W — SMC result.
- `Enable` in 1 — SMC result valid; one cycle per result.
- `rd_valid` out 1 — FIFO head available.
- `rd_ready` in 1 — consumer accepts the head.
- `rd_data` out DATA_W — FIFO head.
- `busy` out 1 — high in `COLLECT`.
- `frame_done` out 1 — one-cycle pulse when the frame completes.
- `overflow` out 1 — sticky; a result was dropped because the FIFO was full.
- `stray` out 1 — sticky; `Enable` was seen outside `COLLECT`.
- `level` out $clog2(DEPTH)+1 — FIFO occupancy.

## Operation

The state machine has three states: `IDLE`, `COLLECT` and `DONE`.

State transitions:
- `IDLE` → `COLLECT` on `start`. This clears the frame counter and `overflow`; `stray` is kept.
- `COLLECT`: each cycle with `Enable`=1, the frame counter increments.
  - If the FIFO is not full, the result is written. If it is full, the result is dropped and `overflow` is set.
- When the counter reaches `FRAME_LEN`, the block enters `DONE` and `frame_done` pulses.
- `DONE` → `IDLE` in one cycle.
- `start` while in `COLLECT` or `DONE` is ignored.
- `Enable` in `IDLE` or `DONE`: the data is discarded and `stray` is set. `stray` is cleared only by reset.

FIFO rules:
- Read and write pointers wrap modulo `DEPTH`.
- Full is `level`==`DEPTH`; empty is `level`==0.
- `rd_valid` = !empty, and `rd_data` always shows the head, combinationally from the storage array.
- A pop occurs on `rd_valid && rd_ready`.
- Simultaneous push and pop:
  - When not empty, both happen and `level` is unchanged.
  - When empty, the write happens, no pop occurs, and `level` goes 0→1.
  - When full, the pop happens first, so the write is accepted and there is no overflow.
- Reads are independent of state. The FIFO may drain during `IDLE`.

## Timing

- Reset values: state=`IDLE`, pointers=0, `level`=0, `rd_valid`=0, `rd_data`=0, `busy`=0, `frame_done`=0, `overflow`=0, `stray`=0, checksum=0.
- Reset mid-frame discards all FIFO contents and frame progress on the next edge.
- Write-to-visibility latency is 1 cycle: with `Enable` at edge N, `rd_valid` and `rd_data` are valid after edge N.
- `busy` is registered. It is high starting the cycle after the `start` edge.
- `frame_done` asserts the cycle after the edge that captured the `FRAME_LEN`-th `Enable`. It lasts exactly one cycle, which coincides with `DONE`.
- `Enable` on the same edge as `start` (while `IDLE`) counts as stray and is not collected.
- `level` updates on the same edge as the push or pop.

## Configuration

- `SMC_COLLECT_CHKSUM_EN` defined:
  - Adds output `chksum` (16 bits), a modulo-2^16 sum of every result written into the FIFO during the current frame.
  - The sum is zero-extended from `DATA_W`.
  - `chksum` is cleared on `start` and holds its value after `DONE` until the next `start`.
  - Dropped (overflow) and stray results are excluded.
- Undefined: the `chksum` port and its adder are absent. All other behaviour is identical.

## Test plan

- Reset, then idle 5 cycles → all outputs 0 and `level`=0. Assert `reset`=0 mid-frame after 3 results → `level`=0, `busy`=0 on the next cycle.
- `start`, then 6 `Enable` pulses carrying 10,20,30,40,50,60 with `rd_ready`=0 → `frame_done` pulses once, `level`=6. Then raise `rd_ready` → reads 10,20,…,60 in order; `overflow`=0. With CHKSUM_EN: `chksum`=210.
- `FRAME_LEN`=12, `DEPTH`=8, `rd_ready`=0, 12 back-to-back results → first 8 stored, `overflow`=1, `level`=8, `frame_done` still pulses.
- `DEPTH`=8 full, `rd_ready`=1 together with `Enable` on the same edge → `level` stays 8, `overflow`=0, and the new value is read last.
- `Enable` pulse with `out_n`=7 in `IDLE` → `stray`=1, `level`=0. A following `start` leaves `stray`=1.
- Continuous `rd_ready`=1 across 3 frames (18 results) → pointers wrap and all 18 values are read in order, each 1 cycle after write.
